// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the five-stage MIPS pipeline.
// Owns HI/LO, runs MULT/MULTU (and DIV/DIVU) behind a busy flag, serves
// MTHI/MTLO writes and MFHI/MFLO reads, and raises md_hazard for the
// hazard unit.
// Optional feature macro: MDU_DIV_EN (divide hardware; when undefined,
// md_op 3/4 behave as NONE).
//
// state | meaning
// IDLE  | nothing in flight; MTHI/MTLO and new MULT/DIV accepted
// RUN   | multi-cycle op counting down; result parked in res_hi/res_lo

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hi,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
`endif
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        commit;

    logic        is_mult;
    logic        is_div;
    logic        is_long;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_wr;

`ifdef MDU_DIV_EN
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
`endif

    // Decode which issued op needs the multi-cycle path
    always_comb begin
        is_mult = start & ((md_op == OP_MULT) | (md_op == OP_MULTU));
`ifdef MDU_DIV_EN
        is_div  = start & ((md_op == OP_DIV) | (md_op == OP_DIVU));
`else
        is_div  = 1'b0;
`endif
        is_long = is_mult | is_div;
    end

    // 64-bit product; sign- or zero-extension makes one multiplier serve both
    always_comb begin
        mul_signed = (md_op == OP_MULT);
        mul_a      = {{32{mul_signed & rs_val[31]}}, rs_val};
        mul_b      = {{32{mul_signed & rt_val[31]}}, rt_val};
        prod       = mul_a * mul_b;
    end

`ifdef MDU_DIV_EN
    // Sign-magnitude divide: quotient truncates toward zero, remainder takes
    // the dividend's sign; the magnitude form also handles 0x80000000 / -1.
    always_comb begin
        div_signed = (md_op == OP_DIV);
        a_neg      = div_signed & rs_val[31];
        b_neg      = div_signed & rt_val[31];
        a_mag      = a_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag      = b_neg ? (~rt_val + 32'd1) : rt_val;
        div_zero   = (rt_val == 32'd0);
        q_mag      = 32'd0;
        r_mag      = 32'd0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem = a_neg ? (~r_mag + 32'd1) : r_mag;
    end
`endif

    // Select the value to park; divide by zero still runs but writes nothing
    always_comb begin
        calc_hi = prod[63:32];
        calc_lo = prod[31:0];
        calc_wr = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div) begin
            calc_hi = rem;
            calc_lo = quo;
            calc_wr = ~div_zero;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_long)      state_nxt = RUN;
            RUN:  if (cnt == 4'd1)  state_nxt = IDLE;
        endcase
    end

    // Outputs: busy from state, hazard raised in the issue cycle itself
    always_comb begin
        busy      = (state == RUN);
        md_hazard = busy | is_long;
        md_out    = rd_hi ? hi : lo;
    end

    // HI/LO, countdown and parked result; HI/LO only change on completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_long) begin
                        cnt    <= is_div ? DIV_LOAD : MULT_LOAD;
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        commit <= calc_wr;
                    end else if (start && (md_op == OP_MTHI)) begin
                        hi <= rs_val;
                    end else if (start && (md_op == OP_MTLO)) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if ((cnt == 4'd1) && commit) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline, sitting alongside the E-stage ALU and owning the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E, runs multi-cycle operations behind a `busy` flag, and serves MFHI/MFLO reads. It drives `md_hazard`, which the hazard/forwarding unit consumes to stall any HI/LO-class instruction held in D.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (one clock; reset sampled on clk)
- start  input  1  E-stage instruction is a HI/LO op this cycle
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved (treated as NONE)
- rs_val  input  32  forwarded E-stage rs operand
- rt_val  input  32  forwarded E-stage rt operand
- rd_hi  input  1  select HI (1) or LO (0) on `md_out`
- busy  output  1  multi-cycle operation in flight
- md_hazard  output  1  `busy | (start & md_op in 1..4)`; to hazard unit
- md_out  output  32  HI when `rd_hi`, else LO (combinational)
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Registers: HI[31:0], LO[31:0], cnt[3:0], busy, pending op[2:0], result latches res_hi/res_lo.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE, `start` & op 1..4: compute result into res_hi/res_lo, load cnt = MULT_CYCLES or DIV_CYCLES, go RUN next edge.
  - MULT: {HI,LO} = signed rs × signed rt (64-bit). MULTU: unsigned.
  - DIV: LO = signed rs / rt (truncate toward zero), HI = signed rs % rt (sign of dividend). DIVU: unsigned.
  - Divide by zero: op still occupies DIV_CYCLES, HI/LO unchanged at completion.
- IDLE, `start` & op 5: HI <= rs_val next edge; op 6: LO <= rs_val. No busy.
- RUN: cnt decrements each edge; on the edge where cnt==1, HI/LO <= res_hi/res_lo, busy <= 0, return IDLE.
- `start` while busy: ignored entirely (any op); hazard unit guarantees it never occurs, bench checks ignore.
- md_op 0 or 7 with start: no effect.
- HI/LO never visible mid-operation: hi/lo/md_out show old values until completion edge.

## Timing
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, cnt=0, state IDLE; `md_hazard`=0 when start=0; `md_out`=0. Reset mid-RUN aborts the op, result discarded.
- MULT started at edge N (start sampled): busy=1 after edge N, through edges N+1..N+MULT_CYCLES-1, HI/LO updated and busy=0 after edge N+MULT_CYCLES. DIV likewise with DIV_CYCLES.
- Back-to-back: new start accepted on the cycle busy is already 0 (edge N+CYCLES), no bubble.
- MTHI/MTLO: visible on `hi`/`lo`/`md_out` the cycle after the issuing edge.
- `md_hazard` rises combinationally in the start cycle so the D-stage MFHI behind a MULT stalls immediately.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU implemented as above.
- Not defined: no divide logic compiled; md_op 3/4 treated as NONE (no busy, HI/LO unchanged, `md_hazard` excludes ops 3/4).

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; md_out tracks rd_hi.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=0 -> busy 10 cycles, HI/LO unchanged.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 in consecutive cycles -> hi/lo updated one cycle after each; MULT then start+MTHI at busy cycle 2 -> MTHI ignored, final HI from MULT.
- MULT in flight, reset pulled low at busy cycle 3 -> next cycle busy=0, HI=LO=0, no later update.
- Without `MDU_DIV_EN`: DIV rs=10, rt=3 -> md_hazard=0, busy stays 0, HI/LO unchanged.
